// File: rtl/spart.sv
// spart: register-mapped UART with a programmable 16x-oversampling baud generator.
// Optional feature macro: SPART_PARITY_EN adds an even-parity bit to TX and RX frames.
module spart #(
    parameter logic [15:0] DEFAULT_DIV = 16'd27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd,
    output logic [2:0] tx_state_dbg,
    output logic [2:0] rx_state_dbg
);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT} rx_state_t;

    // Bus protocol: reads are combinational while iocs && iorw; writes are
    // captured on the rising clock edge while iocs && !iorw. No handshake.
    logic wr_data, wr_div_lo, wr_div_hi, rd_data;
    assign wr_data   = iocs && !iorw && (ioaddr == 2'b00);
    assign wr_div_lo = iocs && !iorw && (ioaddr == 2'b10);
    assign wr_div_hi = iocs && !iorw && (ioaddr == 2'b11);
    assign rd_data   = iocs &&  iorw && (ioaddr == 2'b00);

    logic [15:0] divisor, baud_cnt;
    logic        tick;
    assign tick = (baud_cnt == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            divisor  <= DEFAULT_DIV;
            baud_cnt <= DEFAULT_DIV;
        end else begin
            if (wr_div_lo) divisor[7:0]  <= databus;
            if (wr_div_hi) divisor[15:8] <= databus;
            baud_cnt <= tick ? divisor : baud_cnt - 16'd1;
        end
    end

    // Transmitter
    tx_state_t tx_state, tx_next;
    logic [3:0] tx_tcnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_data;
    logic       tx_adv, tx_done;

    assign tx_adv = tick && (tx_tcnt == 4'd15);

    always_comb begin
        tx_next = tx_state;
        tx_done = 1'b0;
        txd     = 1'b1;
        case (tx_state)
            TX_IDLE:  if (!tbr && tick) tx_next = TX_START;
            TX_START: begin
                txd = 1'b0;
                if (tx_adv) tx_next = TX_DATA;
            end
            TX_DATA: begin
                txd = tx_data[tx_bit];
`ifdef SPART_PARITY_EN
                if (tx_adv && tx_bit == 3'd7) tx_next = TX_PARITY;
`else
                if (tx_adv && tx_bit == 3'd7) tx_next = TX_STOP;
`endif
            end
            TX_PARITY: begin
                txd = ^tx_data;
                if (tx_adv) tx_next = TX_STOP;
            end
            TX_STOP: begin
                if (tx_adv) begin
                    tx_next = TX_IDLE;
                    tx_done = 1'b1;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_tcnt  <= 4'd0;
            tx_bit   <= 3'd0;
            tx_data  <= 8'h00;
            tbr      <= 1'b1;
        end else begin
            tx_state <= tx_next;
            if (tick) tx_tcnt <= (tx_state == TX_IDLE) ? 4'd0 : tx_tcnt + 4'd1;
            if (tx_state == TX_DATA && tx_adv) tx_bit <= tx_bit + 3'd1;
            if (wr_data && tbr) begin
                tx_data <= databus;
                tbr     <= 1'b0;
            end else if (tx_done) begin
                tbr <= 1'b1;
            end
        end
    end

    // Receiver
    rx_state_t rx_state, rx_next;
    logic       rx_s1, rx_s2, rx_prev;
    logic [3:0] rx_tcnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift, rx_buf;
    logic       rx_sample, rx_load, ferr_set, ovr, ferr, perr;

    always_comb begin
        rx_next   = rx_state;
        rx_sample = tick && ((rx_state == RX_START) ? (rx_tcnt == 4'd7) : (rx_tcnt == 4'd15));
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s2) rx_next = RX_START;
            RX_START: if (rx_sample) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA: begin
`ifdef SPART_PARITY_EN
                if (rx_sample && rx_bit == 3'd7) rx_next = RX_PARITY;
`else
                if (rx_sample && rx_bit == 3'd7) rx_next = RX_STOP;
`endif
            end
            RX_PARITY: if (rx_sample) rx_next = RX_STOP;
            RX_STOP:   if (rx_sample) rx_next = rx_s2 ? RX_IDLE : RX_WAIT;
            RX_WAIT:   if (rx_s2) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    assign ferr_set = (rx_state == RX_STOP) && rx_sample && !rx_s2;

`ifdef SPART_PARITY_EN
    logic rx_par_bad, perr_set;
    assign perr_set = (rx_state == RX_STOP) && rx_sample && rx_s2 && rx_par_bad;
    assign rx_load  = (rx_state == RX_STOP) && rx_sample && rx_s2 && !rx_par_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_par_bad <= 1'b0;
            perr       <= 1'b0;
        end else begin
            if (rx_state == RX_IDLE) rx_par_bad <= 1'b0;
            else if (rx_state == RX_PARITY && rx_sample) rx_par_bad <= ^{rx_shift, rx_s2};
            if (rd_data) perr <= 1'b0;
            if (perr_set) perr <= 1'b1;
        end
    end
`else
    assign rx_load = (rx_state == RX_STOP) && rx_sample && rx_s2;
    assign perr    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_tcnt  <= 4'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            rx_buf   <= 8'h00;
            rda      <= 1'b0;
            ferr     <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_next;
            if (rx_state == RX_IDLE || rx_sample) rx_tcnt <= 4'd0;
            else if (tick) rx_tcnt <= rx_tcnt + 4'd1;
            if (rx_state == RX_IDLE) rx_bit <= 3'd0;
            else if (rx_state == RX_DATA && rx_sample) begin
                rx_bit   <= rx_bit + 3'd1;
                rx_shift <= {rx_s2, rx_shift[7:1]};
            end
            if (rd_data) begin
                rda  <= 1'b0;
                ferr <= 1'b0;
                ovr  <= 1'b0;
            end
            // A completing frame beats a same-cycle data read: rda stays set, no overrun.
            if (rx_load) begin
                rx_buf <= rx_shift;
                rda    <= 1'b1;
                if (rda && !rd_data) ovr <= 1'b1;
            end
            if (ferr_set) ferr <= 1'b1;
        end
    end

    logic [7:0] rd_mux;
    always_comb begin
        rd_mux = 8'h00;
        case (ioaddr)
            2'b00: rd_mux = rx_buf;
            2'b01: rd_mux = {3'b000, perr, ovr, ferr, rda, tbr};
            2'b10: rd_mux = divisor[7:0];
            2'b11: rd_mux = divisor[15:8];
            default: rd_mux = 8'h00;
        endcase
    end

    assign databus      = (iocs && iorw) ? rd_mux : 8'hzz;
    assign tx_state_dbg = tx_state;
    assign rx_state_dbg = rx_state;

endmodule

// File: tb/tb_spart.sv
// Directed testbench for spart: register access, TX framing, RX receive/overrun/framing/glitch, parity.
// Expected values assume divisor 3 (one bit = 64 clocks); SPART_PARITY_EN selects 8E1 expectations.
module tb_spart;

    logic       clk = 1'b0;
    logic       rst, iocs, iorw, rxd;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] drv;
    logic       drv_en;
    logic       rda, tbr, txd;
    logic [2:0] tx_state_dbg, rx_state_dbg;
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;

    assign databus = drv_en ? drv : 8'hzz;

    spart dut (
        .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
        .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd),
        .tx_state_dbg(tx_state_dbg), .rx_state_dbg(rx_state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv = d; drv_en = 1'b1;
        @(negedge clk);
        iocs = 1'b0; iorw = 1'b1; drv_en = 1'b0;
    endtask

    task cpu_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        iocs = 1'b1; iorw = 1'b1; ioaddr = a;
        #1 d = databus;
        @(negedge clk);
        iocs = 1'b0;
    endtask

    // Waits for the start bit, then samples each bit mid-period.
    task capture_tx(output logic [7:0] d, output logic pb, output logic st,
                    output int waited, output int fall_cyc);
        d = 8'h00; pb = 1'b0; st = 1'b0;
        for (waited = 0; waited < 200 && txd !== 1'b0; waited++) @(negedge clk);
        fall_cyc = cyc;
        repeat (32) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (64) @(negedge clk);
            d[i] = txd;
        end
`ifdef SPART_PARITY_EN
        repeat (64) @(negedge clk);
        pb = txd;
`endif
        repeat (64) @(negedge clk);
        st = txd;
    endtask

    task rx_send(input logic [7:0] d, input logic pb, input logic st);
        @(negedge clk);
        rxd = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (64) @(negedge clk);
        end
`ifdef SPART_PARITY_EN
        rxd = pb;
        repeat (64) @(negedge clk);
`endif
        rxd = st;
        repeat (64) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task test_reset;
        logic [7:0] r;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b expected 1", txd); end
        n_vec++; if (tbr !== 1'b1) begin n_err++; $display("FAIL reset_tbr: got %b expected 1", tbr); end
        n_vec++; if (rda !== 1'b0) begin n_err++; $display("FAIL reset_rda: got %b expected 0", rda); end
        cpu_read(2'b01, r);
        n_vec++; if (r !== 8'h01) begin n_err++; $display("FAIL reset_status: got %h expected 01", r); end
        cpu_read(2'b10, r);
        n_vec++; if (r !== 8'h1B) begin n_err++; $display("FAIL reset_div_lo: got %h expected 1b", r); end
        cpu_read(2'b11, r);
        n_vec++; if (r !== 8'h00) begin n_err++; $display("FAIL reset_div_hi: got %h expected 00", r); end
        cpu_read(2'b00, r);
        n_vec++; if (r !== 8'h00) begin n_err++; $display("FAIL reset_rx_buf: got %h expected 00", r); end
        cpu_write(2'b10, 8'h03);
        cpu_write(2'b11, 8'h00);
        cpu_read(2'b10, r);
        n_vec++; if (r !== 8'h03) begin n_err++; $display("FAIL div_write: got %h expected 03", r); end
        repeat (40) @(negedge clk);
    endtask

    task test_tx;
        logic [7:0] d;
        logic pb, st;
        int w, fall, rise, expect_len;
        cpu_write(2'b00, 8'hA5);
        n_vec++; if (tbr !== 1'b0) begin n_err++; $display("FAIL tx_tbr_low: got %b expected 0", tbr); end
        capture_tx(d, pb, st, w, fall);
        n_vec++; if (w < 1 || w > 4) begin n_err++; $display("FAIL tx_start_latency: got %0d cycles expected 1..4", w); end
        n_vec++; if (d !== 8'hA5) begin n_err++; $display("FAIL tx_data: got %h expected a5", d); end
`ifdef SPART_PARITY_EN
        n_vec++; if (pb !== 1'b0) begin n_err++; $display("FAIL tx_parity: got %b expected 0", pb); end
        expect_len = 704;
`else
        expect_len = 640;
`endif
        n_vec++; if (st !== 1'b1) begin n_err++; $display("FAIL tx_stop: got %b expected 1", st); end
        for (int i = 0; i < 200 && tbr !== 1'b1; i++) @(negedge clk);
        rise = cyc;
        n_vec++; if (rise - fall !== expect_len) begin n_err++; $display("FAIL tx_frame_len: got %0d expected %0d", rise - fall, expect_len); end
        repeat (10) @(negedge clk);
    endtask

    task test_tx_busy_write;
        logic [7:0] d;
        logic pb, st;
        int w, fall;
        cpu_write(2'b00, 8'h3C);
        cpu_write(2'b00, 8'h55);
        capture_tx(d, pb, st, w, fall);
        n_vec++; if (d !== 8'h3C) begin n_err++; $display("FAIL tx_busy_ignored: got %h expected 3c", d); end
        n_vec++; if (st !== 1'b1) begin n_err++; $display("FAIL tx_busy_stop: got %b expected 1", st); end
        for (int i = 0; i < 200 && tbr !== 1'b1; i++) @(negedge clk);
        n_vec++; if (tbr !== 1'b1) begin n_err++; $display("FAIL tx_busy_tbr: got %b expected 1", tbr); end
        repeat (10) @(negedge clk);
    endtask

    task test_rx;
        logic [7:0] r;
        rx_send(8'h3C, ^8'h3C, 1'b1);
        n_vec++; if (rda !== 1'b1) begin n_err++; $display("FAIL rx_rda: got %b expected 1", rda); end
        cpu_read(2'b01, r);
        n_vec++; if (r !== 8'h03) begin n_err++; $display("FAIL rx_status: got %h expected 03", r); end
        cpu_read(2'b00, r);
        n_vec++; if (r !== 8'h3C) begin n_err++; $display("FAIL rx_data: got %h expected 3c", r); end
        n_vec++; if (rda !== 1'b0) begin n_err++; $display("FAIL rx_rda_clear: got %b expected 0", rda); end
    endtask

    task test_rx_overrun;
        logic [7:0] r;
        rx_send(8'h11, ^8'h11, 1'b1);
        rx_send(8'h22, ^8'h22, 1'b1);
        cpu_read(2'b01, r);
        n_vec++; if (r !== 8'h0B) begin n_err++; $display("FAIL ovr_status: got %h expected 0b", r); end
        cpu_read(2'b00, r);
        n_vec++; if (r !== 8'h22) begin n_err++; $display("FAIL ovr_data: got %h expected 22", r); end
        cpu_read(2'b01, r);
        n_vec++; if (r !== 8'h01) begin n_err++; $display("FAIL ovr_cleared: got %h expected 01", r); end
    endtask

    task test_rx_frame_err;
        logic [7:0] r;
        rx_send(8'h5A, ^8'h5A, 1'b0);
        n_vec++; if (rda !== 1'b0) begin n_err++; $display("FAIL ferr_rda: got %b expected 0", rda); end
        cpu_read(2'b01, r);
        n_vec++; if (r !== 8'h05) begin n_err++; $display("FAIL ferr_status: got %h expected 05", r); end
        n_vec++; if (rx_state_dbg !== 3'd0) begin n_err++; $display("FAIL ferr_rx_idle: got %0d expected 0", rx_state_dbg); end
        cpu_read(2'b00, r);
        n_vec++; if (r !== 8'h22) begin n_err++; $display("FAIL ferr_buf_kept: got %h expected 22", r); end
        cpu_read(2'b01, r);
        n_vec++; if (r !== 8'h01) begin n_err++; $display("FAIL ferr_cleared: got %h expected 01", r); end
    endtask

    task test_rx_glitch;
        logic [7:0] r;
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (6) @(negedge clk);
        n_vec++; if (rx_state_dbg !== 3'd1) begin n_err++; $display("FAIL glitch_start_seen: got %0d expected 1", rx_state_dbg); end
        repeat (60) @(negedge clk);
        n_vec++; if (rx_state_dbg !== 3'd0) begin n_err++; $display("FAIL glitch_rx_idle: got %0d expected 0", rx_state_dbg); end
        cpu_read(2'b01, r);
        n_vec++; if (r !== 8'h01) begin n_err++; $display("FAIL glitch_status: got %h expected 01", r); end
    endtask

    task test_parity;
        logic [7:0] r;
`ifdef SPART_PARITY_EN
        rx_send(8'h07, 1'b0, 1'b1);
        n_vec++; if (rda !== 1'b0) begin n_err++; $display("FAIL perr_rda: got %b expected 0", rda); end
        cpu_read(2'b01, r);
        n_vec++; if (r !== 8'h11) begin n_err++; $display("FAIL perr_status: got %h expected 11", r); end
        cpu_read(2'b00, r);
        rx_send(8'h07, 1'b1, 1'b1);
`else
        rx_send(8'h07, 1'b0, 1'b1);
`endif
        n_vec++; if (rda !== 1'b1) begin n_err++; $display("FAIL parity_good_rda: got %b expected 1", rda); end
        cpu_read(2'b01, r);
        n_vec++; if (r !== 8'h03) begin n_err++; $display("FAIL parity_good_status: got %h expected 03", r); end
        cpu_read(2'b00, r);
        n_vec++; if (r !== 8'h07) begin n_err++; $display("FAIL parity_good_data: got %h expected 07", r); end
    endtask

    task test_reset_mid_frame;
        cpu_write(2'b00, 8'h00);
        for (int i = 0; i < 200 && txd !== 1'b0; i++) @(negedge clk);
        n_vec++; if (txd !== 1'b0) begin n_err++; $display("FAIL midrst_frame_started: got %b expected 0", txd); end
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (txd !== 1'b1) begin n_err++; $display("FAIL midrst_txd: got %b expected 1", txd); end
        n_vec++; if (tbr !== 1'b1) begin n_err++; $display("FAIL midrst_tbr: got %b expected 1", tbr); end
        n_vec++; if (tx_state_dbg !== 3'd0) begin n_err++; $display("FAIL midrst_tx_idle: got %0d expected 0", tx_state_dbg); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; iocs = 1'b0; iorw = 1'b1; ioaddr = 2'b00;
        drv = 8'h00; drv_en = 1'b0; rxd = 1'b1;
        test_reset();
        test_tx();
        test_tx_busy_write();
        test_rx();
        test_rx_overrun();
        test_rx_frame_err();
        test_rx_glitch();
        test_parity();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
